// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: tracks where the user is in a two-operand calculator
// entry (first operand, operator, second operand, enter) from one-cycle key
// pulses, and decodes the key class for the datapath.
// Optional build macro CALC_TIMEOUT_EN adds an idle counter that aborts a
// partial entry after TIMEOUT_CYCLES cycles without a key press.
module calc_key_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_down_onepulse,
  input  logic [3:0] key_code,
  output logic [1:0] state,
  output logic [1:0] press_num_cnt,
  output logic       press_num,
  output logic       press_asm,
  output logic       press_enter,
  output logic [3:0] BCD,
  output logic       reset_en,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_FIRST    = 2'd0,
    ST_OPERATOR = 2'd1,
    ST_SECOND   = 2'd2,
    ST_ENTER    = 2'd3
  } state_e;

  state_e     state_q, state_d, key_state;
  logic [1:0] cnt_q, cnt_d, key_cnt;

  // Key class decode, independent of whether a key is being pressed.
  assign press_num   = (key_code <= 4'd9);
  assign press_asm   = (key_code >= 4'hA) && (key_code <= 4'hC);
  assign press_enter = (key_code == 4'hE);
  assign BCD         = key_code;

  assign state         = state_q;
  assign press_num_cnt = cnt_q;

  // A digit in ENTER starts a fresh calculation, so the datapath is cleared.
  assign reset_en = (state_q == ST_ENTER) && key_down_onepulse && press_num;

  // Next state/count caused by a key pulse alone; unchanged without a pulse.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    key_state = state_q;
    key_cnt   = cnt_q;
    if (key_down_onepulse) begin
      unique case (state_q)
        ST_FIRST: begin
          if (press_num) begin
            if (cnt_q != 2'd2) key_cnt = cnt_q + 2'd1;
          end else if (press_asm && (cnt_q != 2'd0)) begin
            key_state = ST_OPERATOR;
            key_cnt   = 2'd0;
          end
        end
        ST_OPERATOR: begin
          if (press_num) begin
            key_state = ST_SECOND;
            key_cnt   = 2'd1;
          end
        end
        ST_SECOND: begin
          if (press_num) begin
            if (cnt_q != 2'd2) key_cnt = cnt_q + 2'd1;
          end else if (press_enter) begin
            key_state = ST_ENTER;
            key_cnt   = 2'd0;
          end
        end
        ST_ENTER: begin
          if (press_num) begin
            key_state = ST_FIRST;
            key_cnt   = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_TIMEOUT_EN
  localparam logic [26:0] IDLE_LAST = 27'(TIMEOUT_CYCLES - 1);

  logic [26:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;

  // Idle counting and abort; a key pulse on the expiry cycle takes priority.
  always_comb begin
    state_d   = key_state;
    cnt_d     = key_cnt;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    if (key_down_onepulse) begin
      idle_d = '0;
    end else if (state_q != ST_ENTER) begin
      if (idle_q == IDLE_LAST) begin
        state_d   = ST_FIRST;
        cnt_d     = 2'd0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + 27'd1;
      end
    end
  end

  // Idle counter and one-cycle abort pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign state_d = key_state;
  assign cnt_d   = key_cnt;
  assign timeout = 1'b0;
  // The parameter has no effect in this build.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Sequencer state and operand digit count registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_FIRST;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
